// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and per-attempt overflow/underflow pulses.
// Pointers carry an extra wrap bit so full and empty are distinguished without a counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             wr_error,
  output logic             rd_error
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic               full;
  logic               empty;
  logic               wr_ok;
  logic               rd_ok;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
            (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
    rd_ok = rd_en && !empty;
    // A full FIFO still accepts a write when a read frees the oldest slot on the same edge.
    wr_ok = wr_en && (!full || rd_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rdata    <= '0;
      wr_error <= 1'b0;
      rd_error <= 1'b0;
    end else begin
      wr_error <= wr_en && !wr_ok;
      rd_error <= rd_en && !rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + (PTR_WIDTH+1)'(1);
      end
      if (rd_ok) begin
        rdata  <= mem[rd_ptr[PTR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + (PTR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized checks of sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             wr_error;
  logic             rd_error;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] exp_rdata = '0;
  logic             exp_wr_err = 1'b0;
  logic             exp_rd_err = 1'b0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wdata(wdata),
    .rdata(rdata),
    .wr_error(wr_error),
    .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
    check({tag, ".wr_error"}, 32'(wr_error), 32'(exp_wr_err));
    check({tag, ".rd_error"}, 32'(rd_error), 32'(exp_rd_err));
  endtask

  // One clock cycle of stimulus; the model applies FIFO rules to the pre-edge occupancy.
  task automatic step(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit rd_acc;
    bit wr_acc;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wdata = d;
    @(posedge clk);
    rd_acc = r && (q.size() != 0);
    wr_acc = w && ((q.size() < DEPTH) || rd_acc);
    exp_wr_err = w && !wr_acc;
    exp_rd_err = r && !rd_acc;
    if (rd_acc) exp_rdata = q.pop_front();
    if (wr_acc) q.push_back(d);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, WIDTH'($urandom));
  endtask

  task automatic fill(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(tag, 1'b1, 1'b0, WIDTH'($urandom_range(50, 10)));
  endtask

  task automatic drain(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(tag, 1'b0, 1'b1, WIDTH'($urandom));
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    exp_rdata  = '0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
    check_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned bias;
    bit [7:0] first;

    // Reset held two cycles, then an underflow read.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs("reset_state");
    @(negedge clk) rst = 1'b0;
    step("underflow", 1'b0, 1'b1, 8'h00);
    idle("underflow_clear");

    fill("fill16", DEPTH);
    drain("drain16", DEPTH);
    idle("after_drain");

    fill("fill_over", DEPTH);
    step("overflow99", 1'b1, 1'b0, 8'd99);
    idle("overflow_clear");
    for (int unsigned i = 0; i < DEPTH; i++) begin
      step("drain_no99", 1'b0, 1'b1, 8'h00);
      check("not99", 32'(rdata == 8'd99), 32'd0);
    end

    fill("fill_rw", DEPTH);
    first = q[0];
    step("full_rw", 1'b1, 1'b1, 8'hAA);
    check("full_rw.oldest", 32'(rdata), 32'(first));
    drain("drain_rw", DEPTH);
    check("last_is_AA", 32'(rdata), 32'h0000_00AA);

    fill("wrap_w1", 10);
    drain("wrap_r1", 10);
    fill("wrap_w2", 10);
    drain("wrap_r2", 10);

    fill("pre_reset", 5);
    async_reset("mid_reset");
    step("post_reset_w", 1'b1, 1'b0, 8'h11);
    step("post_reset_r1", 1'b0, 1'b1, 8'h00);
    check("first_is_11", 32'(rdata), 32'h0000_0011);
    step("post_reset_r2", 1'b0, 1'b1, 8'h00);
    check("second_underflows", 32'(rd_error), 32'd1);

    // Random traffic with alternating write bias to visit both full and empty.
    for (int unsigned i = 0; i < 600; i++) begin
      bias = ((i / 60) % 2 == 0) ? 80 : 20;
      step("random", $urandom_range(99, 0) < bias, $urandom_range(99, 0) < (100 - bias),
           WIDTH'($urandom));
    end
    async_reset("random_reset");
    for (int unsigned i = 0; i < 100; i++) begin
      step("random2", $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, WIDTH'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
